// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps each instruction through FETCH -> LOADIR -> ISSUE -> EXEC,
// and drives the PC's loadpc/msel. Optional macro FETCH_HALT_EN adds a HALT opcode (3'b111).
module fetch_sequencer #(
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mdata,
  output logic              mread,
  output logic              loadpc,
  output logic              msel,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              exec_mem_req,
  input  logic              exec_done,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  // Handshake: the instruction transfers on a rising edge where instr_valid and
  // instr_accept are both high; instr_valid stays high and instr stays stable until then.

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    LOADIR = 3'd2,
    ISSUE  = 3'd3,
    EXEC   = 3'd4
`ifdef FETCH_HALT_EN
    , HALT = 3'd5
`endif
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  // state is left as a named signal so checkers can bind to it hierarchically
  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RST;
      wait_cnt <= 3'd0;
      instr    <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && wait_cnt != LAT_LAST)
        wait_cnt <= wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;
      if (state == LOADIR)
        instr <= mdata;
      if (state == EXEC && exec_done)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    mread       = 1'b0;
    loadpc      = 1'b0;
    msel        = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      RST: state_next = FETCH;
      FETCH: begin
        mread = 1'b1;
        if (wait_cnt == LAT_LAST)
          state_next = LOADIR;
      end
      LOADIR: begin
        mread  = 1'b1;
        loadpc = 1'b1;
`ifdef FETCH_HALT_EN
        state_next = (mdata[15:13] == 3'b111) ? HALT : ISSUE;
`else
        state_next = ISSUE;
`endif
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_accept)
          state_next = EXEC;
      end
      EXEC: begin
        // execute stage borrows the RAM port in the same cycle it asks
        msel  = exec_mem_req;
        mread = exec_mem_req;
        if (exec_done)
          state_next = FETCH;
      end
`ifdef FETCH_HALT_EN
      HALT: halted = 1'b1;
`endif
      default: state_next = RST;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: random instruction words, random issue stalls and
// execute-stage RAM requests, checked against a transaction-level reference.
module tb_fetch_sequencer;

  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] mdata;
  logic              mread;
  logic              loadpc;
  logic              msel;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_accept;
  logic              exec_mem_req;
  logic              exec_done;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  fetch_sequencer #(.DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mdata(mdata), .mread(mread), .loadpc(loadpc),
    .msel(msel), .instr(instr), .instr_valid(instr_valid),
    .instr_accept(instr_accept), .exec_mem_req(exec_mem_req),
    .exec_done(exec_done), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int  exp_retired = 0;
  bit  exp_halted  = 1'b0;
  bit  in_exec     = 1'b0;
  bit  mon_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mread"}, 32'(mread), 0);
    check({tag, "_loadpc"}, 32'(loadpc), 0);
    check({tag, "_msel"}, 32'(msel), 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_instr"}, 32'(instr), 0);
    check({tag, "_retired"}, 32'(retired), 0);
  endtask

  // Monitor: pops the expected word on every accepted instruction and checks
  // the always-true invariants once per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid && instr_accept) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(instr), 32'hFFFF_FFFF);
        end else begin
          check("issued_instr", 32'(instr), 32'(exp_q.pop_front()));
        end
      end
      if (in_exec) begin
        check("exec_msel", 32'(msel), 32'(exec_mem_req));
        check("exec_mread", 32'(mread), 32'(exec_mem_req));
      end else begin
        check("msel_outside_exec", 32'(msel), 0);
      end
      check("retired", 32'(retired), 32'(exp_retired));
      check("halted", 32'(halted), 32'(exp_halted));
    end
  end

  task automatic fetch_phase(input logic [DATA_W-1:0] w);
    mdata = w;
    for (int i = 0; i < MEM_LAT; i++) begin
      @(negedge clk);
      check("fetch_mread", 32'(mread), 1);
      check("fetch_loadpc", 32'(loadpc), 0);
      check("fetch_valid", 32'(instr_valid), 0);
      step();
    end
    @(negedge clk);
    check("loadir_loadpc", 32'(loadpc), 1);
    check("loadir_mread", 32'(mread), 1);
    check("loadir_valid", 32'(instr_valid), 0);
    step();
  endtask

  // Starts on the edge that enters FETCH; returns on the edge that re-enters FETCH.
  task automatic run_instr(input logic [DATA_W-1:0] w, input bit rst_in_exec);
    int hold;
    int n;
    exp_q.push_back(w);
    fetch_phase(w);
    hold = $urandom_range(0, 4);
    for (int i = 0; i < hold; i++) begin
      exec_done    = 1'($urandom_range(0, 1));
      exec_mem_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("issue_valid", 32'(instr_valid), 1);
      check("issue_instr", 32'(instr), 32'(w));
      check("issue_mread", 32'(mread), 0);
      check("issue_loadpc", 32'(loadpc), 0);
      step();
    end
    exec_done    = 1'b0;
    exec_mem_req = 1'b0;
    instr_accept = 1'b1;
    @(negedge clk);
    check("accept_valid", 32'(instr_valid), 1);
    step();
    instr_accept = 1'b0;
    in_exec      = 1'b1;
    if (rst_in_exec) begin
      exec_mem_req = 1'b1;
      @(negedge clk);
      check("exec_valid", 32'(instr_valid), 0);
      step();
      reset = 1'b1;
      @(negedge clk);
      step();
      reset        = 1'b0;
      exec_mem_req = 1'b0;
      in_exec      = 1'b0;
      exp_retired  = 0;
      @(negedge clk);
      check_idle_zero("rst_exec");
      step();
    end else begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        exec_mem_req = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("exec_valid", 32'(instr_valid), 0);
        check("exec_loadpc", 32'(loadpc), 0);
        step();
      end
      exec_done    = 1'b1;
      exec_mem_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_valid", 32'(instr_valid), 0);
      step();
      exec_done    = 1'b0;
      exec_mem_req = 1'b0;
      in_exec      = 1'b0;
      exp_retired  = (exp_retired + 1) % (1 << CNT_W);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    reset        = 1'b1;
    mdata        = '0;
    instr_accept = 1'b0;
    exec_mem_req = 1'b0;
    exec_done    = 1'b0;

    step();
    mon_en = 1'b1;
    @(negedge clk);
    check_idle_zero("reset1");
    step();
    @(negedge clk);
    check_idle_zero("reset2");
    step();
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("release");
    step();

    for (int k = 0; k < 36; k++) begin
      w = DATA_W'($urandom_range(0, 16'hFFFF));
`ifdef FETCH_HALT_EN
      if (w[15:13] == 3'b111) w[15] = 1'b0;
`else
      if (k == 5) w = 16'hE000;
`endif
      run_instr(w, k == 20);
    end

`ifdef FETCH_HALT_EN
    fetch_phase(16'hE000);
    exp_halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_mread", 32'(mread), 0);
      check("halt_valid", 32'(instr_valid), 0);
      check("halt_loadpc", 32'(loadpc), 0);
      check("halt_instr", 32'(instr), 32'hE000);
      step();
    end
    reset = 1'b1;
    step();
    reset       = 1'b0;
    exp_halted  = 1'b0;
    exp_retired = 0;
    @(negedge clk);
    check_idle_zero("halt_reset");
    step();
`endif

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
